// File: rtl/three_dice_roller_if.sv
// Handshake and result bundle between the dice roller and its consumer.
// The master side requests rolls and acknowledges results; the slave
// side (the roller) reports busy/valid and the three faces.
// Optional macro ROLL_STATS_EN adds the roll_count/triple_count statistics.
interface three_dice_roller_if;
  logic       roll_req;
  logic       res_ack;
  logic       busy;
  logic       res_valid;
  logic [2:0] face1;
  logic [2:0] face2;
  logic [2:0] face3;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       triple;
`ifdef ROLL_STATS_EN
  logic [15:0] roll_count;
  logic [7:0]  triple_count;

  modport master (
    output roll_req, res_ack,
    input  busy, res_valid, face1, face2, face3, d1, d2, d3, triple,
    input  roll_count, triple_count
  );

  modport slave (
    input  roll_req, res_ack,
    output busy, res_valid, face1, face2, face3, d1, d2, d3, triple,
    output roll_count, triple_count
  );
`else
  modport master (
    output roll_req, res_ack,
    input  busy, res_valid, face1, face2, face3, d1, d2, d3, triple
  );

  modport slave (
    input  roll_req, res_ack,
    output busy, res_valid, face1, face2, face3, d1, d2, d3, triple
  );
`endif
endinterface

// File: rtl/three_dice_roller.sv
// Three-dice roller: a free-running 16-bit Galois LFSR drives three mod-6
// face counters during a fixed spin window; the result is then held until
// the consumer acknowledges it.
// Optional macro ROLL_STATS_EN adds roll_count (wrapping) and triple_count
// (saturating) statistics outputs.
module three_dice_roller #(
  parameter int          SPIN_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  three_dice_roller_if.slave bus
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          CNT_W     = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       face1_q, face1_d;
  logic [2:0]       face2_q, face2_d;
  logic [2:0]       face3_q, face3_d;
  logic             triple_q, triple_d;
  logic             start_roll;
  logic             spin_last;

  // Advance a face by one step when its tap is set; 6 wraps back to 1.
  function automatic logic [2:0] step_face(input logic [2:0] f, input logic tap);
    if (!tap) return f;
    return (f >= 3'd6) ? 3'd1 : f + 3'd1;
  endfunction

  assign spin_last  = (state_q == SPIN) && (cnt_q == '0);
  assign start_roll = roll_start_cond(state_q, bus.roll_req, bus.res_ack);

  // A roll starts from IDLE on request, or from DONE when the same cycle also acknowledges.
  function automatic logic roll_start_cond(input state_t s, input logic req, input logic ack);
    return ((s == IDLE) && req) || ((s == DONE) && ack && req);
  endfunction

  // State register plus all datapath flops, reset to the idle/seed values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      cnt_q    <= '0;
      face1_q  <= 3'd1;
      face2_q  <= 3'd1;
      face3_q  <= 3'd1;
      triple_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      face1_q  <= face1_d;
      face2_q  <= face2_d;
      face3_q  <= face3_d;
      triple_q <= triple_d;
    end
  end

  // Next-state logic for the IDLE/SPIN/DONE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.roll_req) state_d = SPIN;
      SPIN: if (cnt_q == '0) state_d = DONE;
      DONE: if (bus.res_ack) state_d = bus.roll_req ? SPIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: LFSR always shifts; faces step only in SPIN using pre-shift taps.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    cnt_d    = cnt_q;
    face1_d  = face1_q;
    face2_d  = face2_q;
    face3_d  = face3_q;
    triple_d = triple_q;
    if (state_q == SPIN) begin
      face1_d = step_face(face1_q, lfsr_q[0]);
      face2_d = step_face(face2_q, lfsr_q[5]);
      face3_d = step_face(face3_q, lfsr_q[10]);
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
    if (spin_last) begin
      triple_d = (face1_d == face2_d) && (face2_d == face3_d);
    end
    if ((state_q == DONE) && bus.res_ack) begin
      triple_d = 1'b0;
    end
    if (start_roll) begin
      cnt_d = CNT_LOAD;
    end
  end

  // Outputs decoded from the registered state and faces.
  always_comb begin
    bus.busy      = (state_q == SPIN);
    bus.res_valid = (state_q == DONE);
    bus.face1     = face1_q;
    bus.face2     = face2_q;
    bus.face3     = face3_q;
    bus.d1        = face1_q[0];
    bus.d2        = face2_q[0];
    bus.d3        = face3_q[0];
    bus.triple    = triple_q;
  end

`ifdef ROLL_STATS_EN
  logic [15:0] roll_count_q, roll_count_d;
  logic [7:0]  triple_count_q, triple_count_d;

  // Statistics registers; both clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_count_q   <= 16'h0000;
      triple_count_q <= 8'h00;
    end else begin
      roll_count_q   <= roll_count_d;
      triple_count_q <= triple_count_d;
    end
  end

  // Count every entry into DONE (wrapping) and every triple (saturating).
  always_comb begin
    roll_count_d   = roll_count_q;
    triple_count_d = triple_count_q;
    if (spin_last) begin
      roll_count_d = roll_count_q + 16'h0001;
      if (triple_d && (triple_count_q != 8'hFF)) triple_count_d = triple_count_q + 8'h01;
    end
  end

  assign bus.roll_count   = roll_count_q;
  assign bus.triple_count = triple_count_q;
`endif

endmodule

// File: tb/tb_three_dice_roller.sv
// Scoreboard bench for three_dice_roller: stimulus predicts each roll with an
// independent LFSR/mod-6 model and queues it; a monitor checks each result
// when res_valid rises. Define ROLL_STATS_EN to also check the statistics.
module tb_three_dice_roller;

  localparam int          SPIN  = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          BULK  = 2000;

  typedef struct packed {
    logic [2:0] f1;
    logic [2:0] f2;
    logic [2:0] f3;
    logic       tr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  exp_t        exp_q[$];
  logic [15:0] m_lfsr;
  logic [2:0]  m_face[3];
  int          m_rolls;
  int          m_triples;
  bit          seen[3][8];
  logic        prev_valid;
  exp_t        save_a;
  exp_t        last_exp;

  three_dice_roller_if dif();

  three_dice_roller #(.SPIN_CYCLES(SPIN), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference LFSR step: right shift, fold the mask in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference LFSR runs alongside the DUT from the same reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Predict a roll sampled at the edge just passed: the next SPIN pre-shift values start at m_lfsr.
  task automatic predictRoll(output exp_t e);
    logic [15:0] l;
    l = m_lfsr;
    for (int k = 0; k < SPIN; k++) begin
      if (l[0])  m_face[0] = (m_face[0] == 3'd6) ? 3'd1 : m_face[0] + 3'd1;
      if (l[5])  m_face[1] = (m_face[1] == 3'd6) ? 3'd1 : m_face[1] + 3'd1;
      if (l[10]) m_face[2] = (m_face[2] == 3'd6) ? 3'd1 : m_face[2] + 3'd1;
      l = lfsr_next(l);
    end
    e.f1 = m_face[0];
    e.f2 = m_face[1];
    e.f3 = m_face[2];
    e.tr = (m_face[0] == m_face[1]) && (m_face[1] == m_face[2]);
    m_rolls++;
    if (e.tr) m_triples++;
    exp_q.push_back(e);
  endtask

  // Raise roll_req (optionally with res_ack) for one edge and queue the prediction.
  task automatic applyStimulus(input bit with_ack);
    exp_t e;
    @(negedge clk);
    dif.roll_req = 1'b1;
    dif.res_ack  = with_ack;
    @(posedge clk);
    #1;
    predictRoll(e);
    last_exp = e;
    @(negedge clk);
    dif.roll_req = 1'b0;
    dif.res_ack  = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},   dif.busy, 1'b0);
    checkOutput({tag, "_valid"},  dif.res_valid, 1'b0);
    checkOutput({tag, "_faces"},  {dif.face1, dif.face2, dif.face3}, {3'd1, 3'd1, 3'd1});
    checkOutput({tag, "_odd"},    {dif.d1, dif.d2, dif.d3}, 3'b111);
    checkOutput({tag, "_triple"}, dif.triple, 1'b0);
`ifdef ROLL_STATS_EN
    checkOutput({tag, "_roll_count"},   dif.roll_count, 16'h0);
    checkOutput({tag, "_triple_count"}, dif.triple_count, 8'h0);
`endif
  endtask

  // Assert reset between edges, check outputs before any edge, release one cycle later.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_face[0] = 3'd1;
    m_face[1] = 3'd1;
    m_face[2] = 3'd1;
    m_rolls   = 0;
    m_triples = 0;
    #1;
    checkResetValues(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for res_valid after a request and check the spin latency.
  task automatic waitResult(input string tag);
    int cyc;
    cyc = 0;
    while (!dif.res_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!dif.res_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout actual=no_res_valid required=res_valid_within_40", tag);
    end else begin
      checkOutput({tag, "_latency"}, cyc, SPIN);
    end
  endtask

  // Monitor: on each rising res_valid, pop the oldest prediction and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (dif.res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result actual=faces_%0d%0d%0d required=no_result",
                   dif.face1, dif.face2, dif.face3);
        end else begin
          e = exp_q.pop_front();
          checkOutput("roll_faces",  {dif.face1, dif.face2, dif.face3}, {e.f1, e.f2, e.f3});
          checkOutput("roll_odd",    {dif.d1, dif.d2, dif.d3}, {e.f1[0], e.f2[0], e.f3[0]});
          checkOutput("roll_triple", dif.triple, e.tr);
        end
        checkOutput("face1_range", (dif.face1 >= 3'd1 && dif.face1 <= 3'd6), 1'b1);
        checkOutput("face2_range", (dif.face2 >= 3'd1 && dif.face2 <= 3'd6), 1'b1);
        checkOutput("face3_range", (dif.face3 >= 3'd1 && dif.face3 <= 3'd6), 1'b1);
        seen[0][dif.face1] = 1'b1;
        seen[1][dif.face2] = 1'b1;
        seen[2][dif.face3] = 1'b1;
      end
      prev_valid = dif.res_valid;
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    dif.roll_req = 1'b0;
    dif.res_ack  = 1'b0;
    prev_valid   = 1'b0;

    // Reset and first roll with cycle-by-cycle latency checks.
    doReset("reset");
    applyStimulus(1'b0);
    save_a = last_exp;
    checkOutput("spin_busy_0",  dif.busy, 1'b1);
    checkOutput("spin_valid_0", dif.res_valid, 1'b0);
    for (int k = 1; k < SPIN; k++) begin
      @(negedge clk);
      checkOutput("spin_busy",  dif.busy, 1'b1);
      checkOutput("spin_valid", dif.res_valid, 1'b0);
    end
    @(negedge clk);
    checkOutput("done_valid", dif.res_valid, 1'b1);
    checkOutput("done_busy",  dif.busy, 1'b0);

    // Withhold res_ack for 20 clocks while roll_req toggles: result must hold.
    for (int i = 0; i < 20; i++) begin
      dif.roll_req = i[0];
      dif.res_ack  = 1'b0;
      @(negedge clk);
      checkOutput("hold_valid", dif.res_valid, 1'b1);
      checkOutput("hold_faces", {dif.face1, dif.face2, dif.face3, dif.d1, dif.d2, dif.d3},
                  {save_a.f1, save_a.f2, save_a.f3, save_a.f1[0], save_a.f2[0], save_a.f3[0]});
    end
    dif.roll_req = 1'b0;

    // Ack and request together: straight back to SPIN with no IDLE bubble.
    applyStimulus(1'b1);
    checkOutput("ackreq_busy",   dif.busy, 1'b1);
    checkOutput("ackreq_valid",  dif.res_valid, 1'b0);
    checkOutput("ackreq_triple", dif.triple, 1'b0);
    waitResult("ackreq");

    // Plain ack returns to IDLE.
    @(negedge clk);
    dif.res_ack = 1'b1;
    @(negedge clk);
    dif.res_ack = 1'b0;
    checkOutput("ack_idle_valid",  dif.res_valid, 1'b0);
    checkOutput("ack_idle_busy",   dif.busy, 1'b0);
    checkOutput("ack_idle_triple", dif.triple, 1'b0);

    // Reset in the middle of a spin, then replay the first roll from the seed.
    applyStimulus(1'b0);
    @(negedge clk);
    @(negedge clk);
    doReset("midspin_reset");
    applyStimulus(1'b0);
    waitResult("reroll");
    checkOutput("reroll_matches_first", {dif.face1, dif.face2, dif.face3},
                {save_a.f1, save_a.f2, save_a.f3});

    // Bulk rolls chained via simultaneous ack+request.
    for (int r = 0; r < BULK; r++) begin
      applyStimulus(1'b1);
      waitResult("bulk");
    end
    @(negedge clk);
    dif.res_ack = 1'b1;
    @(negedge clk);
    dif.res_ack = 1'b0;
    checkOutput("bulk_queue_empty", exp_q.size(), 0);

`ifdef ROLL_STATS_EN
    checkOutput("stat_roll_count",   dif.roll_count, m_rolls[15:0]);
    checkOutput("stat_triple_count", dif.triple_count, (m_triples > 255) ? 255 : m_triples);
`endif

    for (int d = 0; d < 3; d++) begin
      for (int f = 1; f <= 6; f++) begin
        checkOutput($sformatf("seen_die%0d_face%0d", d + 1, f), seen[d][f], 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
